// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin packet-locked sharing of one UART TX port between two byte requesters (UART_ARB_TAG_EN prefixes each grant with TAG0/TAG1)
module uart_tx_arbiter #(
  parameter int MAX_BURST = 16,
  parameter int IDLE_TO = 255,
  parameter logic [7:0] TAG0 = 8'hA0,
  parameter logic [7:0] TAG1 = 8'hA1
) (
  input  logic       clk_clk,
  input  logic       reset_reset,
  input  logic [7:0] req0_data,
  input  logic       req0_valid,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic [7:0] req1_data,
  input  logic       req1_valid,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic [7:0] tx_data,
  output logic       tx_write,
  input  logic       tx_busy,
  output logic [1:0] grant
);
`ifdef UART_ARB_TAG_EN
  localparam bit TAG_EN = 1'b1;
`else
  localparam bit TAG_EN = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, LOCKED, SEND, DRAIN, RELEASE} state_t;
  state_t state, state_n;
  logic ptr, ptr_n, own, own_n, last_q, last_n, first_q, first_n, tag_q, tag_n;
  logic o_valid, x_valid, o_last, hs;
  logic [7:0] o_data, data_n, burst_cnt, burst_n;
  logic [15:0] idle_cnt, idle_n;
  logic [1:0] grant_n;
  always_comb begin
    o_valid = own ? req1_valid : req0_valid;
    x_valid = own ? req0_valid : req1_valid;
    o_data = own ? req1_data : req0_data;
    o_last = own ? req1_last : req0_last;
    hs = state == LOCKED && !tag_q && o_valid && !tx_busy && !reset_reset;
    req0_ready = hs && !own;
    req1_ready = hs && own;
    tx_write = state == SEND && !reset_reset;
    state_n = state;
    ptr_n = ptr;
    own_n = own;
    last_n = last_q;
    first_n = 1'b0;
    tag_n = tag_q;
    burst_n = burst_cnt;
    idle_n = idle_cnt;
    data_n = tx_data;
    grant_n = grant;
    case (state)
      IDLE: if (req0_valid || req1_valid) begin
        own_n = req0_valid && req1_valid ? ptr : req1_valid;
        grant_n = own_n ? 2'b10 : 2'b01;
        burst_n = '0;
        idle_n = '0;
        tag_n = TAG_EN;
        state_n = LOCKED;
      end
      LOCKED: if (tag_q) begin
        if (!tx_busy) begin
          data_n = own ? TAG1 : TAG0;
          last_n = 1'b0;
          tag_n = 1'b0;
          state_n = SEND;
        end
      end else if (hs) begin
        data_n = o_data;
        last_n = o_last;
        burst_n = burst_cnt + 8'd1;
        idle_n = '0;
        state_n = SEND;
      end else if (!x_valid) begin
        idle_n = '0;
      end else if (!o_valid) begin
        idle_n = idle_cnt + 16'd1;
        if (idle_n == 16'(IDLE_TO)) begin
          grant_n = 2'b00;
          ptr_n = !own;
          state_n = RELEASE;
        end
      end
      SEND: begin
        first_n = 1'b1;
        state_n = DRAIN;
      end
      DRAIN: if (!first_q && !tx_busy) begin
        if (last_q || burst_cnt == 8'(MAX_BURST)) begin
          grant_n = 2'b00;
          ptr_n = !own;
          state_n = RELEASE;
        end else begin
          state_n = LOCKED;
        end
      end
      RELEASE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_clk)
    if (reset_reset) begin
      state <= IDLE;
      ptr <= 1'b0;
      own <= 1'b0;
      last_q <= 1'b0;
      first_q <= 1'b0;
      tag_q <= 1'b0;
      burst_cnt <= '0;
      idle_cnt <= '0;
      tx_data <= '0;
      grant <= '0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      own <= own_n;
      last_q <= last_n;
      first_q <= first_n;
      tag_q <= tag_n;
      burst_cnt <= burst_n;
      idle_cnt <= idle_n;
      tx_data <= data_n;
      grant <= grant_n;
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and randomized check of uart_tx_arbiter against an event-timestamp reference model
module tb_uart_tx_arbiter;
  localparam int MB = 16, ITO = 8;
`ifdef UART_ARB_TAG_EN
  localparam bit TAG_EN = 1'b1;
`else
  localparam bit TAG_EN = 1'b0;
`endif
  logic clk_clk = 1'b0, reset_reset = 1'b1;
  logic [7:0] req0_data = 8'h00, req1_data = 8'h00, tx_data;
  logic req0_valid = 1'b0, req0_last = 1'b0, req1_valid = 1'b0, req1_last = 1'b0, tx_busy = 1'b0;
  logic req0_ready, req1_ready, tx_write;
  logic [1:0] grant, gprev;
  uart_tx_arbiter #(.MAX_BURST(MB), .IDLE_TO(ITO)) dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset),
    .req0_data(req0_data), .req0_valid(req0_valid), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_data(req1_data), .req1_valid(req1_valid), .req1_last(req1_last), .req1_ready(req1_ready),
    .tx_data(tx_data), .tx_write(tx_write), .tx_busy(tx_busy), .grant(grant)
  );
  always #5 clk_clk = ~clk_clk;
  int n_cmp, n_err, cyc, bcnt, w0, f, s, rc, p0, p1;
  logic [7:0] q0d[$], q1d[$], w_d[$];
  bit q0l[$], q1l[$];
  int w_c[$], w_o[$], gf_c[$];
  bit en0, en1, force_busy, rnd_bl, hs0, hs1, wseen, known;
  int m_own = -1, m_ptr, m_wr = -1, m_dr = -1, m_burst, m_stall;
  bit m_rel, m_tag, m_last;
  logic [7:0] m_data;
  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: actual %0h required %0h", nm, cyc, act, exp);
    end
  endtask
  task automatic rel();
    m_ptr = 1 - m_own;
    m_own = -1;
    m_rel = 1'b1;
  endtask
  task automatic model_step();
    bit ov, xv, ol, e_hs, e_w;
    logic [7:0] od;
    logic [1:0] e_g;
    ov = m_own == 1 ? req1_valid : req0_valid;
    xv = m_own == 1 ? req0_valid : req1_valid;
    ol = m_own == 1 ? req1_last : req0_last;
    od = m_own == 1 ? req1_data : req0_data;
    e_w = m_wr == cyc && !reset_reset;
    e_hs = m_own >= 0 && m_wr != cyc && m_dr < 0 && !m_tag && ov && !tx_busy && !reset_reset;
    e_g = m_own < 0 ? 2'b00 : m_own == 1 ? 2'b10 : 2'b01;
    if (known) begin
      chk("grant", grant, e_g);
      chk("req0_ready", req0_ready, e_hs && m_own == 0);
      chk("req1_ready", req1_ready, e_hs && m_own == 1);
      chk("tx_write", tx_write, e_w);
      chk("tx_data", tx_data, m_data);
    end
    if (reset_reset) begin
      known = 1'b1;
      m_own = -1; m_ptr = 0; m_wr = -1; m_dr = -1; m_burst = 0; m_stall = 0;
      m_rel = 0; m_tag = 0; m_last = 0; m_data = 8'h00;
    end else if (m_rel) begin
      m_rel = 0;
    end else if (m_own < 0) begin
      if (req0_valid || req1_valid) begin
        m_own = req0_valid && req1_valid ? m_ptr : (req1_valid ? 1 : 0);
        m_burst = 0; m_stall = 0; m_tag = TAG_EN;
      end
    end else if (m_wr == cyc) begin
      m_dr = cyc; m_wr = -1;
    end else if (m_dr >= 0) begin
      if (cyc >= m_dr + 2 && !tx_busy) begin
        m_dr = -1;
        if (m_last || m_burst == MB) rel();
      end
    end else if (m_tag) begin
      if (!tx_busy) begin
        m_tag = 0; m_last = 0; m_wr = cyc + 1;
        m_data = m_own == 1 ? 8'hA1 : 8'hA0;
      end
    end else if (e_hs) begin
      m_data = od; m_last = ol; m_burst++; m_stall = 0; m_wr = cyc + 1;
    end else if (!xv) begin
      m_stall = 0;
    end else if (!ov) begin
      m_stall++;
      if (m_stall == ITO) begin m_stall = 0; rel(); end
    end
  endtask
  initial begin
    forever begin
      @(negedge clk_clk);
      cyc++;
      hs0 = req0_valid && req0_ready;
      hs1 = req1_valid && req1_ready;
      wseen = tx_write;
      if (tx_write) begin
        w_d.push_back(tx_data); w_c.push_back(cyc); w_o.push_back(grant == 2'b10 ? 1 : 0);
      end
      if (gprev != 2'b00 && grant == 2'b00) gf_c.push_back(cyc);
      gprev = grant;
      model_step();
    end
  end
  task automatic drive();
    req0_valid = en0 && q0d.size() > 0;
    req0_data = q0d.size() > 0 ? q0d[0] : 8'h00;
    req0_last = q0l.size() > 0 && q0l[0];
    req1_valid = en1 && q1d.size() > 0;
    req1_data = q1d.size() > 0 ? q1d[0] : 8'h00;
    req1_last = q1l.size() > 0 && q1l[0];
  endtask
  task automatic tick();
    @(posedge clk_clk);
    #1;
    if (hs0 && q0d.size() > 0) begin void'(q0d.pop_front()); void'(q0l.pop_front()); end
    if (hs1 && q1d.size() > 0) begin void'(q1d.pop_front()); void'(q1l.pop_front()); end
    if (wseen) bcnt = rnd_bl ? int'($urandom_range(1, 12)) : 10;
    else if (bcnt > 0) bcnt--;
    tx_busy = bcnt > 0 || force_busy;
    drive();
  endtask
  task automatic do_reset();
    reset_reset = 1'b1;
    en0 = 0; en1 = 0; force_busy = 0;
    q0d.delete(); q0l.delete(); q1d.delete(); q1l.delete();
    repeat (15) tick();
    reset_reset = 1'b0;
    w_d.delete(); w_c.delete(); w_o.delete(); gf_c.delete();
  endtask
  task automatic wait_writes(input int n, input int budget);
    for (int i = 0; i < budget && w_d.size() < n; i++) tick();
    chk("writes_within_budget", w_d.size() >= n, 1);
  endtask
  task automatic wait_fall(input int budget);
    for (int i = 0; i < budget && gf_c.size() == 0; i++) tick();
    chk("release_within_budget", gf_c.size() > 0, 1);
  endtask
  task automatic push(input int r, input int len);
    logic [7:0] b;
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      if (r == 0) begin q0d.push_back(b); q0l.push_back(i == len - 1); end
      else begin q1d.push_back(b); q1l.push_back(i == len - 1); end
    end
  endtask
  initial begin
    do_reset();
    #1;
    chk("reset_grant", grant, 0);
    chk("reset_tx_data", tx_data, 0);
    chk("reset_tx_write", tx_write, 0);
`ifndef UART_ARB_TAG_EN
    q0d = '{8'h11, 8'h22, 8'h33}; q0l = '{0, 0, 1}; en0 = 1;
    tick(); #1;
    chk("t1_grant_idle", grant, 2'b00);
    tick(); #1;
    chk("t1_grant_c1", grant, 2'b01);
    chk("t1_ready_c1", req0_ready, 1);
    wait_writes(3, 200);
    if (w_d.size() >= 3) begin
      chk("t1_byte0", w_d[0], 8'h11);
      chk("t1_byte1", w_d[1], 8'h22);
      chk("t1_byte2", w_d[2], 8'h33);
      chk("t1_gap01_ge11", w_c[1] - w_c[0] >= 11, 1);
      chk("t1_gap12_ge11", w_c[2] - w_c[1] >= 11, 1);
    end
    wait_fall(60);
    q0d = '{8'h77}; q0l = '{1}; q1d = '{8'h88}; q1l = '{1}; en1 = 1;
    wait_writes(5, 200);
    if (w_d.size() >= 5) begin
      chk("t1_ptr_owner", w_o[3], 1);
      chk("t1_ptr_byte", w_d[3], 8'h88);
      chk("t1_next_byte", w_d[4], 8'h77);
    end
    do_reset();
    q0d = '{8'h01, 8'h02, 8'h03, 8'h04}; q0l = '{0, 1, 0, 1};
    q1d = '{8'h91, 8'h92}; q1l = '{0, 1}; en0 = 1; en1 = 1;
    wait_writes(6, 400);
    if (w_d.size() >= 6) begin
      chk("t2_seq_owner", {w_o[0][0], w_o[1][0], w_o[2][0], w_o[3][0], w_o[4][0], w_o[5][0]}, 6'b001100);
      chk("t2_byte2", w_d[2], 8'h91);
      chk("t2_byte4", w_d[4], 8'h03);
    end
    do_reset();
    for (int i = 0; i < 20; i++) begin q1d.push_back(8'(8'h40 + i)); q1l.push_back(i == 19); end
    en1 = 1;
    tick(); tick();
    q0d = '{8'hC0}; q0l = '{1}; en0 = 1;
    wait_writes(21, 800);
    if (w_d.size() >= 21) begin
      s = 0;
      for (int i = 0; i < 16; i++) s += w_o[i];
      chk("t3_burst_owner_req1", s, 16);
      chk("t3_switch_owner", w_o[16], 0);
      chk("t3_switch_byte", w_d[16], 8'hC0);
      chk("t3_resume_byte17", w_d[17], 8'h50);
      chk("t3_resume_owner", w_o[17], 1);
    end
    do_reset();
    q0d = '{8'h61, 8'h62, 8'h63}; q0l = '{0, 0, 1}; q1d = '{8'h71}; q1l = '{1}; en0 = 1;
    wait_writes(1, 100);
    w0 = w_c.size() > 0 ? w_c[0] : 0;
    en0 = 0; en1 = 1; drive();
    wait_fall(100);
    if (gf_c.size() > 0) chk("t4_release_cycle", gf_c[0] - w0, 20);
    wait_writes(2, 100);
    en0 = 1;
    wait_writes(4, 300);
    if (w_d.size() >= 4) begin
      chk("t4_req1_owner", w_o[1], 1);
      chk("t4_req1_byte", w_d[1], 8'h71);
      chk("t4_req0_byte2", w_d[2], 8'h62);
      chk("t4_req0_byte3", w_d[3], 8'h63);
    end
    do_reset();
    force_busy = 1;
    q0d = '{8'h5A}; q0l = '{1}; en0 = 1;
    rc = 0;
    repeat (30) begin tick(); #1; rc += req0_ready; end
    chk("t5_ready_while_busy", rc, 0);
    chk("t5_no_write_while_busy", w_d.size(), 0);
    force_busy = 0;
    tick();
    f = cyc + 1;
    wait_writes(1, 20);
    if (w_c.size() > 0) chk("t5_write_after_busy", w_c[0] - f, 1);
`else
    q1d = '{8'h55}; q1l = '{1}; en1 = 1;
    wait_writes(2, 200);
    if (w_d.size() >= 2) begin
      chk("tag_byte", w_d[0], 8'hA1);
      chk("tag_payload", w_d[1], 8'h55);
    end
    wait_fall(60);
    chk("tag_single_release", gf_c.size(), 1);
`endif
    do_reset();
    rnd_bl = 1;
    for (int t = 0; t < 5000; t++) begin
      if (t % 50 == 0) begin p0 = 10 + 40 * int'($urandom_range(0, 2)); p1 = 10 + 40 * int'($urandom_range(0, 2)); end
      if ($urandom_range(0, 19) == 0 && q0d.size() < 30) push(0, $urandom_range(1, 24));
      if ($urandom_range(0, 19) == 0 && q1d.size() < 30) push(1, $urandom_range(1, 24));
      en0 = $urandom_range(0, 99) < p0;
      en1 = $urandom_range(0, 99) < p1;
      reset_reset = $urandom_range(0, 799) == 0;
      tick();
    end
    reset_reset = 0; rnd_bl = 0; en0 = 1; en1 = 1;
    for (int i = 0; i < 6000 && !(q0d.size() == 0 && q1d.size() == 0 && grant == 2'b00); i++) tick();
    chk("random_drained", q0d.size() + q1d.size() + grant, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
